tx_eight_ten_ctrl: RTL and testbench
====================================

Name: tx_eight_ten_ctrl

Overview:
Control stage that feeds the 10-bit UART TX datapath. It accepts a 10-bit word through a start/busy handshake, latches it, and drives `tx_en`, the held word `tx_d` and the bit index `bit_cnto` at the baud rate. The datapath turns these into the serial line: start bit, tx_d[0..9], stop bit. Bit indices run 0..11, and each index is held for CLKS_PER_BIT clocks.

Parameters:
- CLKS_PER_BIT, default 16: clock cycles per serial bit. Legal range 2..65535. The baud counter is 16 bits wide.

Ports:
- clk  in  1: system clock; all state updates on the rising edge.
- rst  in  1: synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
- tx_start  in  1: request to send tx_din. Sampled only while tx_ready=1.
- tx_din  in  10: word to transmit. Sampled in the accept cycle only.
- tx_ready  out  1: high in IDLE; request may be accepted.
- tx_busy  out  1: high while a frame is in progress (equals tx_en).
- tx_done  out  1: one-cycle pulse after the stop bit completes.
- tx_en  out  1: enable to the datapath. High for the whole frame.
- tx_d  out  10: latched word to the datapath. Stable for the whole frame.
- bit_cnto  out  10: current bit index to the datapath, 0..11.

Behaviour:
- Reset (rst=0 at an edge), values after that edge:
  - state=IDLE, tx_en=0, tx_busy=0, tx_ready=1, tx_done=0.
  - tx_d=10'd0, bit_cnto=10'd0, baud_cnt=0.
  - Reset has priority over every other input.
- Reset mid-frame: the frame aborts at the next edge with all reset values above. No tx_done pulse is produced.
- States are IDLE and SEND.
- IDLE:
  - tx_ready=1, tx_en=0, bit_cnto=0, baud_cnt=0.
  - If tx_start=1 at an edge: tx_d<=tx_din, tx_en<=1, tx_ready<=0, state<=SEND, bit_cnto=0, baud_cnt=0.
  - The start bit is therefore on the line from the cycle after the accept edge (one-cycle latency).
- SEND:
  - Each edge: baud_cnt increments.
  - When baud_cnt==CLKS_PER_BIT-1: baud_cnt<=0 and bit_cnto increments.
  - Exception: if bit_cnto==11 at that point, the frame ends. Next cycle has state=IDLE, tx_en=0, bit_cnto=0, tx_ready=1, tx_done=1.
- Frame timing:
  - tx_en is high for exactly 12*CLKS_PER_BIT cycles.
  - Each bit_cnto value k (0..11) is held for exactly CLKS_PER_BIT consecutive cycles.
  - bit_cnto never exceeds 11.
- tx_done:
  - High exactly one cycle, which is the first IDLE cycle after the frame.
  - Cleared on the following edge regardless of inputs.
- Requests while busy: tx_start in SEND is ignored (not queued). tx_din changes in SEND do not affect tx_d.
- Back-to-back frames: tx_start=1 in the tx_done cycle is accepted. The next frame's tx_en rises one cycle after tx_done, giving a minimum one-cycle idle (line high) between frames.
- tx_d after a frame: retains the last word until the next accept or reset.
- Arithmetic: counters are unsigned. baud_cnt wrap is explicit at CLKS_PER_BIT-1, with no natural overflow. bit_cnto is a 10-bit port whose upper 6 bits are always 0.

Test Plan:
1. Single frame (CLKS_PER_BIT=4): rst=1, then one-cycle tx_start with tx_din=10'h2A5 at cycle 0.
   - Expected: tx_en high for cycles 1..48; tx_d=10'h2A5 throughout; bit_cnto=k during cycles 4k+1..4k+4; tx_done=1 only at cycle 49; tx_ready=1 again at cycle 49.
   - With the datapath attached, the line reads 0,1,0,1,0,0,1,0,1,0,1,1, each bit for 4 cycles.
2. Ignored request: accept 10'h0F0, then pulse tx_start with tx_din=10'h3FF at cycle 20.
   - Expected: tx_d stays 10'h0F0; exactly one tx_done at cycle 49; no second frame starts.
3. Back-to-back: hold tx_start=1 continuously with tx_din=10'h155, then 10'h2AA.
   - Expected: second accept occurs in the tx_done cycle (49); tx_en low only at cycle 49, high again 50..97; tx_d=10'h2AA from cycle 50; second tx_done at cycle 98.
4. Reset mid-frame: drive rst=0 for one edge at cycle 25 (bit_cnto=6).
   - Expected: at cycle 26, tx_en=0, bit_cnto=0, tx_d=0, tx_ready=1; no tx_done in cycles 25..60.
5. Reset priority: rst=0 and tx_start=1 on the same edge.
   - Expected: remains IDLE with tx_en=0; a tx_start=1 at the next edge with rst=1 is accepted normally.
6. Minimum baud (CLKS_PER_BIT=2): one frame with tx_din=10'h001.
   - Expected: tx_en high exactly 24 cycles; each bit_cnto value held 2 cycles; tx_done one cycle after tx_en falls.

Source files
------------

// File: rtl/tx_eight_ten_ctrl.sv
// tx_eight_ten_ctrl: control stage ahead of the 10-bit UART TX datapath.
// Accepts a word on a start/ready handshake and sequences the bit index
// 0..11 (start bit, ten data bits, stop bit) at CLKS_PER_BIT clocks per bit.
module tx_eight_ten_ctrl #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [9:0] tx_din,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_en,
    output logic [9:0] tx_d,
    output logic [9:0] bit_cnto
);

    // Last baud count of a bit period and last bit index of a frame.
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  BIT_LAST  = 4'd11;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [15:0] baud_cnt;
    logic [15:0] baud_cnt_n;
    logic [3:0]  bit_cnt;
    logic [3:0]  bit_cnt_n;
    logic [9:0]  tx_d_n;
    logic        tx_done_n;

    // True on the final clock of a bit period; the wrap is explicit so the
    // counter never relies on natural 16-bit overflow.
    function automatic logic baud_wrap(input logic [15:0] cnt);
        return cnt == BAUD_LAST;
    endfunction

    // True when the current bit index is the stop bit.
    function automatic logic frame_last(input logic [3:0] idx);
        return idx == BIT_LAST;
    endfunction

    // State and datapath registers; reset aborts any frame without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
            bit_cnt  <= 4'd0;
            tx_d     <= 10'd0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_cnt  <= bit_cnt_n;
            tx_d     <= tx_d_n;
            tx_done  <= tx_done_n;
        end
    end

    // Next-state logic: accept in IDLE, count baud ticks and bit indices in SEND.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_cnt_n  = bit_cnt;
        tx_d_n     = tx_d;
        tx_done_n  = 1'b0;
        case (state)
            IDLE: begin
                baud_cnt_n = 16'd0;
                bit_cnt_n  = 4'd0;
                if (tx_start) begin
                    tx_d_n  = tx_din;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (baud_wrap(baud_cnt)) begin
                    baud_cnt_n = 16'd0;
                    if (frame_last(bit_cnt)) begin
                        // Stop bit finished: the first IDLE cycle carries tx_done,
                        // and a tx_start seen then starts the next frame.
                        bit_cnt_n = 4'd0;
                        state_n   = IDLE;
                        tx_done_n = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 16'd1;
                end
            end
            default: begin
                state_n    = IDLE;
                baud_cnt_n = 16'd0;
                bit_cnt_n  = 4'd0;
            end
        endcase
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        tx_en    = (state == SEND);
        tx_busy  = (state == SEND);
        tx_ready = (state == IDLE);
        bit_cnto = {6'd0, bit_cnt};
    end

endmodule

// File: tb/tb_tx_eight_ten_ctrl.sv
// Bench for tx_eight_ten_ctrl: one instance at 4 clocks/bit, one at 2.
// Accepted words go into a per-instance queue and are popped when tx_done fires.
module tb_tx_eight_ten_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       start_i;
    logic [1:0][9:0]  din_i;
    logic [1:0]       rdy_o;
    logic [1:0]       busy_o;
    logic [1:0]       done_o;
    logic [1:0]       en_o;
    logic [1:0][9:0]  d_o;
    logic [1:0][9:0]  bc_o;

    int checks   = 0;
    int failures = 0;

    logic [9:0] q0[$];
    logic [9:0] q1[$];

    typedef struct {
        logic [9:0] din;
        int         sel;
        int         cpb;
        int         poke;
        int         exp_len;
        int         exp_done;
    } vec_t;

    tx_eight_ten_ctrl #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .tx_start (start_i[0]),
        .tx_din   (din_i[0]),
        .tx_ready (rdy_o[0]),
        .tx_busy  (busy_o[0]),
        .tx_done  (done_o[0]),
        .tx_en    (en_o[0]),
        .tx_d     (d_o[0]),
        .bit_cnto (bc_o[0])
    );

    tx_eight_ten_ctrl #(.CLKS_PER_BIT(2)) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .tx_start (start_i[1]),
        .tx_din   (din_i[1]),
        .tx_ready (rdy_o[1]),
        .tx_busy  (busy_o[1]),
        .tx_done  (done_o[1]),
        .tx_en    (en_o[1]),
        .tx_d     (d_o[1]),
        .bit_cnto (bc_o[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every tx_done must match the oldest outstanding accepted word.
    always @(negedge clk) begin
        if (done_o[0]) begin
            if (q0.size() == 0) chk("unexpected_done_cpb4", 1, 0);
            else chk("done_word_cpb4", int'(d_o[0]), int'(q0.pop_front()));
        end
        if (done_o[1]) begin
            if (q1.size() == 0) chk("unexpected_done_cpb2", 1, 0);
            else chk("done_word_cpb2", int'(d_o[1]), int'(q1.pop_front()));
        end
    end

    task automatic push_word(input int sel, input logic [9:0] w);
        if (sel == 0) q0.push_back(w);
        else q1.push_back(w);
    endtask

    // Drive one accept cycle (cycle 0); returns positioned in cycle 1.
    task automatic accept(input int sel, input logic [9:0] w);
        chk("accept_ready", int'(rdy_o[sel]), 1);
        start_i[sel] = 1'b1;
        din_i[sel]   = w;
        push_word(sel, w);
        step();
        start_i[sel] = 1'b0;
        din_i[sel]   = 10'($urandom);
    endtask

    task automatic run_vec(input vec_t v);
        int en_cnt  = 0;
        int done_at = -1;
        accept(v.sel, v.din);
        for (int c = 1; c <= v.exp_done + 1; c++) begin
            if (en_o[v.sel]) en_cnt++;
            if (done_o[v.sel] && done_at < 0) done_at = c;
            if (c <= v.exp_len) begin
                chk("frame_en", int'(en_o[v.sel]), 1);
                chk("frame_busy", int'(busy_o[v.sel]), 1);
                chk("frame_ready", int'(rdy_o[v.sel]), 0);
                chk("frame_word", int'(d_o[v.sel]), int'(v.din));
                chk("frame_bit", int'(bc_o[v.sel]), (c - 1) / v.cpb);
                chk("frame_done_low", int'(done_o[v.sel]), 0);
            end else if (c == v.exp_done) begin
                chk("done_pulse", int'(done_o[v.sel]), 1);
                chk("end_en", int'(en_o[v.sel]), 0);
                chk("end_ready", int'(rdy_o[v.sel]), 1);
                chk("end_bit", int'(bc_o[v.sel]), 0);
                chk("end_word_kept", int'(d_o[v.sel]), int'(v.din));
            end else begin
                chk("done_cleared", int'(done_o[v.sel]), 0);
                chk("idle_en", int'(en_o[v.sel]), 0);
            end
            if (c == v.poke) begin
                start_i[v.sel] = 1'b1;
                din_i[v.sel]   = 10'h3FF;
            end else begin
                start_i[v.sel] = 1'b0;
            end
            step();
        end
        chk("en_cycles", en_cnt, v.exp_len);
        chk("done_cycle", done_at, v.exp_done);
        for (int k = 0; k < 4; k++) begin
            chk("no_restart", int'(en_o[v.sel]), 0);
            step();
        end
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{din: 10'h2A5, sel: 0, cpb: 4, poke: 0,  exp_len: 48, exp_done: 49};
        vecs[1] = '{din: 10'h000, sel: 0, cpb: 4, poke: 0,  exp_len: 48, exp_done: 49};
        vecs[2] = '{din: 10'h3FF, sel: 0, cpb: 4, poke: 0,  exp_len: 48, exp_done: 49};
        vecs[3] = '{din: 10'h0F0, sel: 0, cpb: 4, poke: 20, exp_len: 48, exp_done: 49};
        vecs[4] = '{din: 10'h001, sel: 1, cpb: 2, poke: 0,  exp_len: 24, exp_done: 25};
        vecs[5] = '{din: 10'h2AA, sel: 1, cpb: 2, poke: 7,  exp_len: 24, exp_done: 25};

        rst     = 1'b0;
        start_i = '0;
        din_i   = '0;
        step();
        step();
        for (int s = 0; s < 2; s++) begin
            chk("rst_en", int'(en_o[s]), 0);
            chk("rst_busy", int'(busy_o[s]), 0);
            chk("rst_ready", int'(rdy_o[s]), 1);
            chk("rst_done", int'(done_o[s]), 0);
            chk("rst_word", int'(d_o[s]), 0);
            chk("rst_bit", int'(bc_o[s]), 0);
        end
        rst = 1'b1;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back: tx_start held high, second accept lands on the tx_done cycle.
        start_i[0] = 1'b1;
        din_i[0]   = 10'h155;
        q0.push_back(10'h155);
        step();
        din_i[0] = 10'h2AA;
        for (int c = 1; c <= 48; c++) begin
            chk("b2b_en1", int'(en_o[0]), 1);
            chk("b2b_word1", int'(d_o[0]), 10'h155);
            chk("b2b_bit1", int'(bc_o[0]), (c - 1) / 4);
            step();
        end
        chk("b2b_gap_en", int'(en_o[0]), 0);
        chk("b2b_done1", int'(done_o[0]), 1);
        chk("b2b_ready", int'(rdy_o[0]), 1);
        q0.push_back(10'h2AA);
        step();
        start_i[0] = 1'b0;
        for (int c = 50; c <= 97; c++) begin
            chk("b2b_en2", int'(en_o[0]), 1);
            chk("b2b_word2", int'(d_o[0]), 10'h2AA);
            chk("b2b_bit2", int'(bc_o[0]), (c - 50) / 4);
            chk("b2b_done_low", int'(done_o[0]), 0);
            step();
        end
        chk("b2b_done2", int'(done_o[0]), 1);
        chk("b2b_end_en", int'(en_o[0]), 0);
        step();
        chk("b2b_done2_cleared", int'(done_o[0]), 0);
        chk("b2b_no_third", int'(en_o[0]), 0);
        step();

        // Reset wins over a simultaneous tx_start; the next start is accepted.
        rst        = 1'b0;
        start_i[0] = 1'b1;
        din_i[0]   = 10'h333;
        step();
        chk("rstprio_en", int'(en_o[0]), 0);
        chk("rstprio_ready", int'(rdy_o[0]), 1);
        chk("rstprio_word", int'(d_o[0]), 0);
        rst = 1'b1;
        q0.push_back(10'h333);
        step();
        start_i[0] = 1'b0;
        chk("rstprio_accept_en", int'(en_o[0]), 1);
        chk("rstprio_accept_word", int'(d_o[0]), 10'h333);
        chk("rstprio_accept_bit", int'(bc_o[0]), 0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        q0.delete();
        step();

        // Reset mid-frame at cycle 25 aborts without a done pulse.
        accept(0, 10'h1C3);
        for (int c = 1; c < 25; c++) step();
        chk("midrst_pre_bit", int'(bc_o[0]), 6);
        chk("midrst_pre_en", int'(en_o[0]), 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        q0.delete();
        chk("midrst_en", int'(en_o[0]), 0);
        chk("midrst_bit", int'(bc_o[0]), 0);
        chk("midrst_word", int'(d_o[0]), 0);
        chk("midrst_ready", int'(rdy_o[0]), 1);
        for (int c = 26; c <= 60; c++) begin
            chk("midrst_no_done", int'(done_o[0]), 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
